frame_aligner: RTL and testbench

Downstream of the 2-lane LVDS ISERDES front end for the LTC ADC. Consumes the 8-bit deserialized frame-clock word and the two 8-bit data-lane words in the sample_clk domain, and drives the ISERDES bitslip input until the frame word matches the expected pattern. Once aligned, it re-interleaves the two DDR lanes into 16-bit ADC samples with a valid flag. It also monitors lock continuously and re-aligns on persistent mismatch.

---
 rtl/frame_aligner_pkg.sv | 21 ++
 rtl/frame_aligner_lane_interleave.sv | 33 +++
 rtl/frame_aligner.sv | 128 ++++++++++++
 tb/tb_frame_aligner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_aligner_pkg.sv
// Shared types and constants for the LTC ADC frame aligner.
// The alignment FSM states and the widths of its counters live here.
package frame_aligner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    SETTLE,
    LOCKED,
    FAIL
  } state_t;

  localparam logic [7:0] DEFAULT_PATTERN = 8'hF0;

  localparam int SLIP_W  = 4;
  localparam int WAIT_W  = 4;
  localparam int MATCH_W = 8;
  localparam int ERR_W   = 4;

endpackage

// File: rtl/frame_aligner_lane_interleave.sv
// Registered bit-interleaver: merges the two DDR lane words into one ADC sample.
// Lane A carries the odd sample bits and lane B the even ones, both MSB first.
module lane_interleave (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  data_a,
  input  logic [7:0]  data_b,
  input  logic        valid_in,
  output logic [15:0] sample,
  output logic        sample_valid
);

  logic [15:0] woven;

  always_comb begin
    woven = '0;
    for (int i = 0; i < 8; i++) begin
      woven[2*i+1] = data_a[i];
      woven[2*i]   = data_b[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample       <= woven;
      sample_valid <= valid_in;
    end
  end

endmodule

// File: rtl/frame_aligner.sv
// Frame aligner for the 2-lane LTC ADC ISERDES: drives bitslip until the frame
// word matches, holds lock with mismatch tolerance, and emits interleaved samples.
module frame_aligner
  import frame_aligner_pkg::*;
#(
  parameter logic [7:0]  FRAME_PATTERN = DEFAULT_PATTERN,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned MAX_SLIPS     = 8,
  parameter int unsigned UNLOCK_ERRORS = 4
) (
  input  logic        sample_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  frame_word,
  input  logic [7:0]  data_a,
  input  logic [7:0]  data_b,
  output logic        bitslip,
  output logic        locked,
  output logic        align_err,
  output logic [3:0]  slip_count,
  output logic [15:0] sample,
  output logic        sample_valid
);

  localparam logic [WAIT_W-1:0]  SETTLE_INIT = WAIT_W'(SETTLE_CYCLES);
  localparam logic [MATCH_W-1:0] LOCK_LAST   = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [SLIP_W-1:0]  SLIP_MAX    = SLIP_W'(MAX_SLIPS);
  localparam logic [ERR_W-1:0]   ERR_LAST    = ERR_W'(UNLOCK_ERRORS - 1);

  state_t               state, state_nxt;
  logic [SLIP_W-1:0]    slip_cnt, slip_cnt_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [MATCH_W-1:0]   match_cnt, match_cnt_nxt;
  logic [ERR_W-1:0]     err_cnt, err_cnt_nxt;
  logic                 frame_match;

  assign frame_match = (frame_word == FRAME_PATTERN);

  // enable low behaves like reset for the FSM so a bitslip in flight is dropped
  always_ff @(posedge sample_clk) begin
    if (!reset_n || !enable) begin
      state     <= IDLE;
      slip_cnt  <= '0;
      wait_cnt  <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      slip_cnt  <= slip_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      match_cnt <= match_cnt_nxt;
      err_cnt   <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    slip_cnt_nxt  = slip_cnt;
    wait_cnt_nxt  = wait_cnt;
    match_cnt_nxt = match_cnt;
    err_cnt_nxt   = err_cnt;
    case (state)
      IDLE: begin
        state_nxt     = CHECK;
        slip_cnt_nxt  = '0;
        wait_cnt_nxt  = '0;
        match_cnt_nxt = '0;
        err_cnt_nxt   = '0;
      end
      CHECK: begin
        if (frame_match) begin
          if (match_cnt == LOCK_LAST) begin
            state_nxt     = LOCKED;
            match_cnt_nxt = '0;
            err_cnt_nxt   = '0;
          end else begin
            match_cnt_nxt = match_cnt + 1'b1;
          end
        end else begin
          match_cnt_nxt = '0;
          state_nxt     = (slip_cnt == SLIP_MAX) ? FAIL : SLIP;
        end
      end
      SLIP: begin
        if (slip_cnt != SLIP_MAX) slip_cnt_nxt = slip_cnt + 1'b1;
        wait_cnt_nxt = SETTLE_INIT;
        state_nxt    = SETTLE;
      end
      SETTLE: begin
        // leaving on the last count keeps pulses SETTLE_CYCLES+2 cycles apart
        if (wait_cnt != '0) wait_cnt_nxt = wait_cnt - 1'b1;
        if (wait_cnt <= 1) state_nxt = CHECK;
      end
      LOCKED: begin
        if (frame_match) begin
          err_cnt_nxt = '0;
        end else if (err_cnt == ERR_LAST) begin
          err_cnt_nxt   = '0;
          slip_cnt_nxt  = '0;
          match_cnt_nxt = '0;
          state_nxt     = SLIP;
        end else begin
          err_cnt_nxt = err_cnt + 1'b1;
        end
      end
      FAIL: state_nxt = FAIL;
      default: state_nxt = IDLE;
    endcase
  end

  assign bitslip    = (state == SLIP);
  assign locked     = (state == LOCKED);
  assign align_err  = (state == FAIL);
  assign slip_count = slip_cnt;

  // sample_valid qualifies sample in the same cycle; there is no backpressure
  lane_interleave u_lane_interleave (
    .clk          (sample_clk),
    .reset_n      (reset_n),
    .data_a       (data_a),
    .data_b       (data_b),
    .valid_in     (enable && (state == LOCKED) && frame_match),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

endmodule

// File: tb/tb_frame_aligner.sv
// Directed-plus-random bench for frame_aligner with a bit-weaving sample model,
// a bitslip-driven frame rotation model and pulse-timing bookkeeping.
module tb_frame_aligner;

  logic        sample_clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  frame_word;
  logic [7:0]  data_a;
  logic [7:0]  data_b;
  logic        bitslip;
  logic        locked;
  logic        align_err;
  logic [3:0]  slip_count;
  logic [15:0] sample;
  logic        sample_valid;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          pulse_q[$];
  logic [15:0] exp_q[$];
  logic        model_locked = 1'b0;
  logic        slip_model   = 1'b0;

  frame_aligner dut (
    .sample_clk   (sample_clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .frame_word   (frame_word),
    .data_a       (data_a),
    .data_b       (data_b),
    .bitslip      (bitslip),
    .locked       (locked),
    .align_err    (align_err),
    .slip_count   (slip_count),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  initial sample_clk = 1'b0;
  always #5 sample_clk = ~sample_clk;

  function automatic logic [15:0] weave(input logic [7:0] a, input logic [7:0] b);
    int v;
    v = 0;
    for (int i = 7; i >= 0; i--) v = v * 4 + int'((a >> i) & 8'd1) * 2 + int'((b >> i) & 8'd1);
    return v[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: predict sample/valid from the inputs, advance, then compare.
  task automatic tick(input logic exp_lk);
    logic [15:0] es;
    logic        ev;
    es = reset_n ? weave(data_a, data_b) : 16'h0000;
    ev = reset_n && enable && model_locked && (frame_word == 8'hF0);
    exp_q.push_back(es);
    @(posedge sample_clk);
    #1;
    cyc++;
    check("sample", sample, exp_q.pop_front());
    check("sample_valid", {15'd0, sample_valid}, {15'd0, ev});
    check("locked", {15'd0, locked}, {15'd0, exp_lk});
    model_locked = exp_lk;
    if (bitslip === 1'b1) begin
      pulse_q.push_back(cyc);
      if (slip_model) frame_word = {frame_word[6:0], frame_word[7]};
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bitslip"}, {15'd0, bitslip}, 16'd0);
    check({tag, "_align_err"}, {15'd0, align_err}, 16'd0);
    check({tag, "_slip_count"}, {12'd0, slip_count}, 16'd0);
  endtask

  task automatic restart_log();
    cyc = 0;
    pulse_q.delete();
  endtask

  initial begin
    int bad_run;

    // 1: reset with random inputs, then released with enable low
    reset_n = 1'b0;
    enable = 1'($urandom_range(0, 1));
    frame_word = 8'($urandom);
    data_a = 8'($urandom);
    data_b = 8'($urandom);
    repeat (3) begin
      tick(1'b0);
      check_idle("reset");
      frame_word = 8'($urandom);
      data_a = 8'($urandom);
      data_b = 8'($urandom);
    end
    reset_n = 1'b1;
    enable = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;
    repeat (2) begin
      tick(1'b0);
      check_idle("released");
    end

    // 2: already-aligned frame locks after 16 matches with no bitslip
    restart_log();
    enable = 1'b1;
    frame_word = 8'hF0;
    data_a = 8'h02;
    data_b = 8'h03;
    repeat (16) tick(1'b0);
    tick(1'b1);
    repeat (3) tick(1'b1);
    check("aligned_sample", sample, 16'h000D);
    check("aligned_pulses", 16'(pulse_q.size()), 16'd0);
    check("aligned_slip_count", {12'd0, slip_count}, 16'd0);

    // 3: frame starts three rotations away from the pattern
    enable = 1'b0;
    tick(1'b0);
    check_idle("disable");
    restart_log();
    frame_word = 8'h1E;
    slip_model = 1'b1;
    enable = 1'b1;
    repeat (34) tick(1'b0);
    tick(1'b1);
    slip_model = 1'b0;
    check("rot_pulses", 16'(pulse_q.size()), 16'd3);
    check("rot_first_pulse", 16'(pulse_q[0]), 16'd2);
    check("rot_spacing_1", 16'(pulse_q[1] - pulse_q[0]), 16'd6);
    check("rot_spacing_2", 16'(pulse_q[2] - pulse_q[1]), 16'd6);
    check("rot_slip_count", {12'd0, slip_count}, 16'd3);

    // 5: random data while locked with short error bursts that must not drop lock
    bad_run = 0;
    for (int i = 0; i < 40; i++) begin
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      if (bad_run < 3 && $urandom_range(0, 3) == 0) begin
        frame_word = 8'($urandom_range(0, 255));
        if (frame_word == 8'hF0) frame_word = 8'hF1;
        bad_run++;
      end else begin
        frame_word = 8'hF0;
        bad_run = 0;
      end
      tick(1'b1);
    end
    frame_word = 8'hF0;
    tick(1'b1);
    restart_log();
    for (int i = 0; i < 3; i++) begin
      frame_word = 8'h0F;
      data_a = 8'($urandom);
      tick(1'b1);
    end
    frame_word = 8'hF0;
    tick(1'b1);
    tick(1'b1);
    check("burst3_pulses", 16'(pulse_q.size()), 16'd0);
    frame_word = 8'h78;
    repeat (3) tick(1'b1);
    tick(1'b0);
    check("unlock_bitslip", {15'd0, bitslip}, 16'd1);
    check("unlock_slip_count", {12'd0, slip_count}, 16'd0);
    frame_word = 8'hF0;
    tick(1'b0);
    check("unlock_pulse_width", {15'd0, bitslip}, 16'd0);
    check("unlock_slip_count_after", {12'd0, slip_count}, 16'd1);

    // 4: stuck frame exhausts the slips and latches align_err
    enable = 1'b0;
    tick(1'b0);
    check_idle("pre_fail");
    restart_log();
    frame_word = 8'h00;
    enable = 1'b1;
    repeat (49) tick(1'b0);
    check("fail_not_yet", {15'd0, align_err}, 16'd0);
    tick(1'b0);
    check("fail_align_err", {15'd0, align_err}, 16'd1);
    check("fail_pulses", 16'(pulse_q.size()), 16'd8);
    check("fail_last_pulse", 16'(pulse_q[7]), 16'd44);
    check("fail_slip_count", {12'd0, slip_count}, 16'd8);
    repeat (10) tick(1'b0);
    check("fail_sticky", {15'd0, align_err}, 16'd1);
    check("fail_no_more_pulses", 16'(pulse_q.size()), 16'd8);
    enable = 1'b0;
    tick(1'b0);
    check_idle("fail_cleared");
    restart_log();
    enable = 1'b1;
    repeat (3) tick(1'b0);
    check("resume_pulses", 16'(pulse_q.size()), 16'd1);

    // 6a: reset while settling
    restart_log();
    reset_n = 1'b0;
    enable = 1'b0;
    data_a = 8'($urandom);
    data_b = 8'($urandom);
    tick(1'b0);
    check_idle("settle_reset");
    reset_n = 1'b1;
    repeat (8) tick(1'b0);
    check("settle_reset_pulses", 16'(pulse_q.size()), 16'd0);

    // 6b: enable dropped during the bitslip cycle
    restart_log();
    enable = 1'b1;
    repeat (2) tick(1'b0);
    check("slip_cycle_bitslip", {15'd0, bitslip}, 16'd1);
    enable = 1'b0;
    tick(1'b0);
    check_idle("slip_cycle_disable");
    repeat (8) tick(1'b0);
    check("slip_cycle_pulses", 16'(pulse_q.size()), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
